// File: rtl/q7_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : q7_arith_pkg
// Purpose  : State encoding and default width shared by the arithmetic blocks.
// Revision : 1.0
// ============================================================================
package q7_arith_pkg;

    localparam int Q7_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } q7_state_t;

endpackage
`default_nettype wire

// File: rtl/q7_shiftsubdiv.sv
`default_nettype none
// ============================================================================
// Module   : q7_shiftsubdiv
// Purpose  : Sequential restoring shift-subtract divider, 2N/N -> N quotient/remainder.
// Revision : 1.0
// ============================================================================
module q7_shiftsubdiv
    import q7_arith_pkg::*;
#(
    parameter int N = Q7_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2*N-1:0]   a_in,
    input  logic [N-1:0]     b_in,
    output logic [N-1:0]     q_out,
    output logic [N-1:0]     r_out,
    output logic             busy,
    output logic             stop,
    output logic             err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    q7_state_t       r_state, w_state_nx;
    logic [N:0]      r_a,     w_a_nx;
    logic [N-1:0]    r_q,     w_q_nx;
    logic [N-1:0]    r_d,     w_d_nx;
    logic [CW-1:0]   r_cnt,   w_cnt_nx;
    logic [N-1:0]    r_qout,  w_qout_nx;
    logic [N-1:0]    r_rout,  w_rout_nx;

    logic [2*N:0]    w_aq_sh;
    logic [N:0]      w_a_sh;
    logic [N+1:0]    w_trial;
    logic            w_ge;
    logic [N:0]      w_a_it;
    logic [N-1:0]    w_q_it;
    logic            w_ovf;

    // One restoring step: shift {A,Q}, try A-D, keep the difference if it did not borrow.
    always_comb begin
        w_aq_sh = {r_a, r_q} << 1;
        w_a_sh  = w_aq_sh[2*N:N];
        w_trial = {1'b0, w_a_sh} - {2'b00, r_d};
        w_ge    = ~w_trial[N+1];
        w_a_it  = w_ge ? w_trial[N:0] : w_a_sh;
        w_q_it  = {w_aq_sh[N-1:1], w_ge};
        w_ovf   = (b_in == '0) || (a_in[2*N-1:N] >= b_in);
    end

    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_q_nx     = r_q;
        w_d_nx     = r_d;
        w_cnt_nx   = r_cnt;
        w_qout_nx  = r_qout;
        w_rout_nx  = r_rout;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    if (w_ovf) begin
                        w_state_nx = ERR;
                        w_qout_nx  = '1;
                        w_rout_nx  = '0;
                    end else begin
                        w_state_nx = CALC;
                        w_a_nx     = {1'b0, a_in[2*N-1:N]};
                        w_q_nx     = a_in[N-1:0];
                        w_d_nx     = b_in;
                        w_cnt_nx   = '0;
                    end
                end
            end
            CALC: begin
                w_a_nx   = w_a_it;
                w_q_nx   = w_q_it;
                w_cnt_nx = r_cnt + 1'b1;
                if (r_cnt == CW'(N-1)) begin
                    w_state_nx = DONE;
                    w_qout_nx  = w_q_it;
                    w_rout_nx  = w_a_it[N-1:0];
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_qout  <= '0;
            r_rout  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_q     <= w_q_nx;
            r_d     <= w_d_nx;
            r_cnt   <= w_cnt_nx;
            r_qout  <= w_qout_nx;
            r_rout  <= w_rout_nx;
        end
    end

    assign q_out = r_qout;
    assign r_out = r_rout;
    assign busy  = (r_state == CALC);
    assign stop  = (r_state == DONE) || (r_state == ERR);
    assign err   = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_q7_shiftsubdiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_q7_shiftsubdiv
// Purpose  : Directed table-driven bench for the shift-subtract divider.
// Revision : 1.0
// ============================================================================
module tb_q7_shiftsubdiv;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a_in;
    logic [3:0] b_in;
    logic [3:0] q_out;
    logic [3:0] r_out;
    logic       busy;
    logic       stop;
    logic       err;

    int checks   = 0;
    int failures = 0;

    q7_shiftsubdiv #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .q_out (q_out),
        .r_out (r_out),
        .busy  (busy),
        .stop  (stop),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        int         q;
        int         r;
        int         e;
        int         lat;
        int         bcy;
    } vec_t;

    vec_t vecs [0:3];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then count edges until stop (bounded).
    task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                         output int lat, output int bcy);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        bcy = busy ? 1 : 0;
        while (!stop && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcy++;
        end
    endtask

    initial begin
        int lat, bcy;

        vecs[0] = '{a: 8'd225, b: 4'd15, q: 15, r: 0, e: 0, lat: 5, bcy: 4};
        vecs[1] = '{a: 8'd100, b: 4'd7,  q: 14, r: 2, e: 0, lat: 5, bcy: 4};
        vecs[2] = '{a: 8'd17,  b: 4'd0,  q: 15, r: 0, e: 1, lat: 1, bcy: 0};
        vecs[3] = '{a: 8'd240, b: 4'd15, q: 15, r: 0, e: 1, lat: 1, bcy: 0};

        reset = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #50;
        check("reset_q",    int'(q_out), 0);
        check("reset_r",    int'(r_out), 0);
        check("reset_busy", int'(busy),  0);
        check("reset_stop", int'(stop),  0);
        check("reset_err",  int'(err),   0);
        #35;
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat, bcy);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bcy, vecs[i].bcy);
            check($sformatf("v%0d_q", i), int'(q_out), vecs[i].q);
            check($sformatf("v%0d_r", i), int'(r_out), vecs[i].r);
            check($sformatf("v%0d_err", i), int'(err), vecs[i].e);
        end

        // Second start in CALC must be ignored.
        @(negedge clk);
        a_in = 8'd200; b_in = 4'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        @(posedge clk); #1;
        lat++;
        @(negedge clk);
        a_in = 8'd9; b_in = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        while (!stop && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ign_latency", lat, 5);
        check("ign_q", int'(q_out), 15);
        check("ign_r", int'(r_out), 5);
        check("ign_err", int'(err), 0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        a_in = 8'd200; b_in = 4'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid_busy_before_rst", int'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_q",    int'(q_out), 0);
        check("arst_r",    int'(r_out), 0);
        check("arst_busy", int'(busy),  0);
        check("arst_stop", int'(stop),  0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
        end
        check("post_rst_stop", int'(stop), 0);
        check("post_rst_busy", int'(busy), 0);
        do_op(8'd9, 4'd3, lat, bcy);
        check("post_rst_latency", lat, 5);
        check("post_rst_q", int'(q_out), 3);
        check("post_rst_r", int'(r_out), 0);
        check("post_rst_err", int'(err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/q7_shiftsubdiv.md
Name: q7_shiftsubdiv

Overview:
- Sequential restoring shift-subtract divider.
- Inverse of the team's shift-add multiplier: accepts a 2n-bit dividend (product width) and an n-bit divisor.
- Produces an n-bit quotient and an n-bit remainder in n iteration cycles.
- Uses the same start/stop handshake as the multiplier, so the two blocks can run back-to-back in the arithmetic datapath.

Parameters:
- n, 4, operand width; divisor, quotient and remainder are n bits, dividend is 2n bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request; sampled on rising clk when the block is not busy.
- a_in  input  2n  dividend.
- b_in  input  n  divisor.
- q_out  output  n  quotient.
- r_out  output  n  remainder.
- busy  output  1  high while iterating.
- stop  output  1  result valid; held until the next accepted start.
- err  output  1  overflow or divide-by-zero; valid when stop=1.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, all registers 0.
  - q_out=0, r_out=0, busy=0, stop=0, err=0.
- States:
  - IDLE: waiting.
  - CALC: iterating.
  - DONE: result held.
  - ERR: result held with err=1.
- Accepting start:
  - start=1 at a rising edge while in IDLE, DONE or ERR is accepted.
  - a_in and b_in are latched on that edge.
  - stop and err clear on that same edge.
- Error check at acceptance:
  - If b_in==0 or a_in[2n-1:n] >= b_in, the quotient does not fit.
  - Next state is ERR: err=1, stop=1, q_out = all ones, r_out=0.
  - Latency is 1 edge; the block never enters CALC.
- Normal path:
  - Load A (n+1 bits) = {0, a_in[2n-1:n]}, Q = a_in[n-1:0], D = b_in, cnt = 0.
  - State goes to CALC.
- Each CALC edge:
  - Shift {A,Q} left by 1.
  - T = A_shifted - {0,D}, computed at n+2 bits.
  - If T is non-negative: A = T[n:0], Q[0] = 1. Otherwise A is kept and Q[0] = 0.
  - cnt increments.
  - After the n-th CALC edge, state goes to DONE.
- DONE: q_out = Q, r_out = A[n-1:0], stop=1, busy=0.
- Timing:
  - stop rises exactly n+1 rising edges after the edge that accepted start.
  - busy=1 for exactly n cycles, in CALC only.
- Boundary conditions:
  - start while in CALC is ignored; the operands and the in-flight result are unaffected.
  - Holding start high in DONE or ERR re-accepts the operands every time the block returns to DONE or ERR; a single-cycle pulse is the normal usage.
  - Reset asserted mid-CALC aborts immediately with no output. After release the block is in IDLE and needs a new start.
  - The remainder is always < divisor, and quotient*divisor + remainder equals the dividend whenever err=0.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package q7_arith_pkg holds:
  - the state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2, ERR=2'd3);
  - the default width constant n.
- The multiplier adopts the same package.
- No sub-module: control FSM and datapath fit in one module of roughly 150-200 lines.
- Optional helper q7_subtrial: a combinational (n+1)-bit trial subtract returning difference and borrow. Use it only if the team wants it shared with a future non-restoring variant.

Test Plan:
- n=4, reset low 85 ns then high; a_in=225, b_in=15, 1-cycle start pulse -> after 5 edges stop=1, q_out=15, r_out=0, err=0 (inverts the 15x15 multiplier case).
- a_in=100, b_in=7 -> q_out=14, r_out=2, err=0; busy high for exactly 4 cycles.
- a_in=17, b_in=0 -> one edge later stop=1, err=1, q_out=4'hF, r_out=0; busy never asserts.
- a_in=240, b_in=15 (high nibble 15 >= 15) -> err=1 overflow, stop after 1 edge.
- a_in=200, b_in=13: pulse start, pulse start again at CALC cycle 2 with a_in=9, b_in=3 -> second start ignored; result q_out=15, r_out=5.
- a_in=200, b_in=13: drop reset at CALC cycle 2 -> all outputs 0 asynchronously; after release stays IDLE with stop=0 until a new start; then a_in=9, b_in=3 -> q_out=3, r_out=0.
